// File: rtl/vendo_pkg.sv
// Shared definitions for the vending coin scheduler: core state codes, coin
// encoding and the issue FSM state type.
package vendo_pkg;

  localparam logic [2:0] ST_A = 3'b000;
  localparam logic [2:0] ST_B = 3'b001;
  localparam logic [2:0] ST_C = 3'b010;
  localparam logic [2:0] ST_D = 3'b011;
  localparam logic [2:0] ST_E = 3'b100;
  localparam logic [2:0] ST_F = 3'b101;

  localparam logic COIN_P1 = 1'b0;
  localparam logic COIN_P5 = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } issue_state_t;

  // The core only accepts a coin in its collecting states; change states and
  // undefined codes are treated as busy.
  function automatic logic core_ready(input logic [2:0] cstate);
    logic rdy;
    case (cstate)
      ST_A, ST_B, ST_C: rdy = 1'b1;
      ST_D, ST_E, ST_F: rdy = 1'b0;
      default:          rdy = 1'b0;
    endcase
    return rdy;
  endfunction

endpackage

// File: rtl/vendo_coin_fifo.sv
// Single-bit synchronous FIFO holding queued coins (0 = 1p, 1 = 5p).
// Pointers carry an extra MSB so full and empty are distinguishable.
module vendo_coin_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic                      pop,
  input  logic                      din,
  output logic                      dout,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push on full is still taken.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign level   = wr_ptr - rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/vendo_coin_sched.sv
// Coin scheduler in front of the vending core: synchronises and queues coins,
// issues them one at a time as p1/p5 pulses, stretches LEDs, counts dispenses.
module vendo_coin_sched
  import vendo_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int STRETCH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          coin1_raw,
  input  logic                          coin5_raw,
  input  logic [2:0]                    core_cstate,
  input  logic                          core_disp,
  input  logic                          core_change,
  output logic                          p1,
  output logic                          p5,
  output logic                          disp_led,
  output logic                          change_led,
  output logic                          coin_drop,
  output logic                          overflow,
  output logic [7:0]                    vend_count,
  output logic [$clog2(FIFO_DEPTH):0]   q_level
);

  localparam int SW = $clog2(STRETCH + 1);

  logic [SYNC_STAGES-1:0] sync1;
  logic [SYNC_STAGES-1:0] sync5;
  logic                   prev1;
  logic                   prev5;
  logic                   edge1;
  logic                   edge5;

  logic                   rr;
  logic                   hold_v;
  logic                   hold_c;
  logic                   hold_nxt_v;
  logic                   hold_nxt_c;
  logic                   push;
  logic                   push_coin;
  logic                   lost_extra;
  logic                   drop_now;
  logic                   first_coin;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   head;
  logic                   pop;
  issue_state_t           state;

  logic [SW-1:0]          disp_cnt;
  logic [SW-1:0]          change_cnt;
  logic                   disp_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync5 <= '0;
      prev1 <= 1'b0;
      prev5 <= 1'b0;
    end else begin
      sync1 <= {sync1[SYNC_STAGES-2:0], coin1_raw};
      sync5 <= {sync5[SYNC_STAGES-2:0], coin5_raw};
      prev1 <= sync1[SYNC_STAGES-1];
      prev5 <= sync5[SYNC_STAGES-1];
    end
  end

  assign edge1 = sync1[SYNC_STAGES-1] & ~prev1;
  assign edge5 = sync5[SYNC_STAGES-1] & ~prev5;

  // The hold register always drains first; a new coin that cannot be pushed
  // this cycle takes its place. Only one push reaches the queue per cycle.
  always_comb begin
    push       = 1'b0;
    push_coin  = COIN_P1;
    hold_nxt_v = 1'b0;
    hold_nxt_c = COIN_P1;
    lost_extra = 1'b0;
    first_coin = rr ? COIN_P5 : COIN_P1;
    if (hold_v) begin
      push      = 1'b1;
      push_coin = hold_c;
      if (edge1 && edge5) begin
        hold_nxt_v = 1'b1;
        hold_nxt_c = first_coin;
        lost_extra = 1'b1;
      end else if (edge1 || edge5) begin
        hold_nxt_v = 1'b1;
        hold_nxt_c = edge5 ? COIN_P5 : COIN_P1;
      end
    end else if (edge1 && edge5) begin
      push       = 1'b1;
      push_coin  = first_coin;
      hold_nxt_v = 1'b1;
      hold_nxt_c = ~first_coin;
    end else if (edge1 || edge5) begin
      push      = 1'b1;
      push_coin = edge5 ? COIN_P5 : COIN_P1;
    end
  end

  assign pop      = (state == IDLE) && !fifo_empty && core_ready(core_cstate);
  assign drop_now = (push && fifo_full && !pop) || lost_extra;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr        <= 1'b0;
      hold_v    <= 1'b0;
      hold_c    <= COIN_P1;
      coin_drop <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      hold_v    <= hold_nxt_v;
      hold_c    <= hold_nxt_c;
      coin_drop <= drop_now;
      if (drop_now) begin
        overflow <= 1'b1;
      end
      if (edge1 && edge5) begin
        rr <= ~rr;
      end
    end
  end

  vendo_coin_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_coin),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (q_level)
  );

  // Coin handshake: a coin leaves the queue only when the FSM is IDLE and the
  // core is ready; the core sees exactly one single-cycle p1/p5 pulse for it,
  // followed by a GAP cycle so its state can settle before the next pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      p1    <= 1'b0;
      p5    <= 1'b0;
    end else begin
      p1 <= 1'b0;
      p5 <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            state <= ISSUE;
            p1    <= (head == COIN_P1);
            p5    <= (head == COIN_P5);
          end
        end
        ISSUE:   state <= GAP;
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Retriggerable stretchers: every high cycle reloads the full length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_cnt   <= '0;
      change_cnt <= '0;
    end else begin
      if (core_disp) begin
        disp_cnt <= SW'(STRETCH);
      end else if (disp_cnt != '0) begin
        disp_cnt <= disp_cnt - SW'(1);
      end
      if (core_change) begin
        change_cnt <= SW'(STRETCH);
      end else if (change_cnt != '0) begin
        change_cnt <= change_cnt - SW'(1);
      end
    end
  end

  assign disp_led   = (disp_cnt != '0);
  assign change_led = (change_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      disp_prev  <= 1'b0;
      vend_count <= 8'd0;
    end else begin
      disp_prev <= core_disp;
      if (core_disp && !disp_prev && (vend_count != 8'd255)) begin
        vend_count <= vend_count + 8'd1;
      end
    end
  end

endmodule
